regfile_dump: RTL
=================

# regfile_dump

Sequential reader for the CPU register file. On a start request it walks a contiguous, optionally wrapping range of register addresses through one RegFile read port. It captures each ReadData word and streams it out as (address, data) beats on a valid/ready interface. It sits beside the datapath for debug dumps and register-state checking, and drives the read-address side of RegFile while the core writes through the write port.

## Interface
- NUM_REGS, 32, number of architectural registers; must be 2**ADDR_W
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- Start  in  1  request a dump; sampled only in IDLE
- FirstReg  in  ADDR_W  first register of range; captured with Start
- LastReg  in  ADDR_W  last register of range; captured with Start
- ReadReg  out  ADDR_W  address to RegFile read port (ReadReg1 or ReadReg2)
- ReadData  in  DATA_W  combinational read data from RegFile for ReadReg
- DumpValid  out  1  beat valid
- DumpReady  in  1  sink accepts beat
- DumpAddr  out  ADDR_W  register index of current beat
- DumpData  out  DATA_W  captured register value of current beat
- Busy  out  1  high from accepted Start through the last handshake
- Done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: Busy=0, DumpValid=0. If Start=1, capture FirstReg into the address counter and LastReg into the end register, then go to READ. Start is ignored in every state other than IDLE.
- READ: ReadReg = address counter. At the clock edge, DumpData <= ReadData and DumpAddr <= counter, then go to HOLD.
- HOLD: DumpValid=1. DumpAddr and DumpData stay stable until the handshake, even if RegFile is written meanwhile, because the beat is a snapshot.
- Handshake in HOLD is DumpValid & DumpReady at the edge:
  - if counter == end register, go to DONE;
  - otherwise counter <= counter + 1 modulo NUM_REGS, then go to READ.
- DONE: Done=1 for exactly one cycle, Busy=0, then go to IDLE.
- Wrap-around: if FirstReg > LastReg, the walk goes FirstReg..NUM_REGS-1, then 0..LastReg. The beat count is ((LastReg - FirstReg) mod NUM_REGS) + 1. FirstReg == LastReg yields exactly one beat.
- The full range is FirstReg=0, LastReg=NUM_REGS-1, giving 32 beats. Register 0 is dumped like any other register; its value is whatever RegFile returns.
- ReadReg holds the counter value in all states, and resets to 0.
- DumpValid may not be withdrawn before the handshake. DumpReady may toggle freely.

## Timing
- Reset value of every output while reset_n=0: ReadReg=0, DumpValid=0, DumpAddr=0, DumpData=0, Busy=0, Done=0. The state is IDLE.
- Reset asserted mid-dump aborts immediately. There is no Done pulse, and no beat is emitted after release.
- Start accepted at edge N: READ during cycle N+1, DumpValid=1 from cycle N+2.
- Per beat: one READ cycle plus at least one HOLD cycle. With DumpReady tied high, throughput is 1 beat per 2 cycles.
- A dump of K beats with DumpReady=1 takes 2K cycles from Start to the last handshake. Done is high the following cycle, so Done first appears 2K+1 cycles after the Start edge.
- Start is accepted again on the cycle after DONE, since the block is back in IDLE.

## Test plan
- Preload RegFile r0..r31 with 0x100+k. Dump 0..31 with DumpReady=1 -> 32 beats with DumpAddr=k and DumpData=0x100+k, valid every other cycle. Done is pulsed once, 65 cycles after Start, and Busy is low thereafter.
- Wrap dump FirstReg=30, LastReg=1 -> exactly 4 beats, with addresses 30, 31, 0, 1 in order, then one Done pulse.
- Single register FirstReg=LastReg=7 -> 1 beat (7, 0x107). Done is high 3 cycles after the Start edge.
- Backpressure: hold DumpReady=0 for 5 cycles on beat 3, and write r3=0xDEADBEEF during the stall -> DumpData stays 0x103 and DumpValid stays high. No beat is skipped or duplicated.
- Start pulsed while Busy with FirstReg=20 -> ignored; the original range completes unchanged.
- Drive reset_n low during beat 10 of a full dump -> all outputs 0 immediately. After release there is no Done pulse and no DumpValid until a new Start.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: walks a (possibly wrapping) register range through one RegFile read port and streams (addr, data) beats
//   clock, reset_n       : clock, asynchronous active-low reset
//   Start/FirstReg/LastReg : dump request and inclusive range, sampled in IDLE only
//   ReadReg/ReadData     : RegFile read port (address out, combinational data in)
//   DumpValid/DumpReady  : beat handshake; DumpAddr/DumpData hold a snapshot until accepted
//   Busy/Done            : dump in progress / one-cycle completion pulse
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              Busy,
  output logic              Done
);
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
  state_t state, nextState;
  logic [ADDR_W-1:0] counter, endReg;
  logic accept, lastBeat;
  assign accept    = (state == HOLD) && DumpReady;
  assign lastBeat  = counter == endReg;
  assign ReadReg   = counter;
  assign DumpValid = state == HOLD;
  assign Busy      = (state == READ) || (state == HOLD);
  assign Done      = state == DONE;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: nextState = Start ? READ : IDLE;
      READ: nextState = HOLD;
      HOLD: nextState = DumpReady ? (lastBeat ? DONE : READ) : HOLD;
      DONE: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      endReg   <= '0;
      DumpAddr <= '0;
      DumpData <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && Start) begin
        counter <= FirstReg;
        endReg  <= LastReg;
      end
      if (state == READ) begin
        DumpAddr <= counter;
        DumpData <= ReadData;
      end
      // wrap explicitly at the top register so the walk continues from r0
      if (accept && !lastBeat)
        counter <= (counter == ADDR_W'(NUM_REGS - 1)) ? '0 : counter + ADDR_W'(1);
    end
  end
endmodule
